// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel-timing master (DrawX/DrawY, sync, blank, frame count)
//   vga_clk      pixel clock, all logic on rising edge
//   reset        synchronous active-high reset
//   DrawX/DrawY  pixel/line counters, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   hs/vs        active-low syncs aligned to DrawX/DrawY
//   blank        1 = visible pixel
//   line_start   pulse while DrawX==0; frame_start pulse while DrawX==0 && DrawY==0
//   frame_count  frames completed since reset, wraps mod 2^16
//   hs_d/vs_d/blank_d  hs/vs/blank delayed PIPE_DELAY cycles to match renderer RGB latency
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        hs_d,
    output logic        vs_d,
    output logic        blank_d
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [9:0] HV     = 10'(H_VISIBLE);
    localparam logic [9:0] VV     = 10'(V_VISIBLE);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL above 1024 do not fit 10-bit counters");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be 0..7");
    end

    logic       w_x_end;
    logic       w_y_end;
    logic [9:0] w_nx;
    logic [9:0] w_ny;

    assign w_x_end = DrawX == X_LAST;
    assign w_y_end = DrawY == Y_LAST;
    assign w_nx    = w_x_end ? 10'd0 : DrawX + 10'd1;
    assign w_ny    = w_x_end ? (w_y_end ? 10'd0 : DrawY + 10'd1) : DrawY;

    // Decode from the next counter value so every output flips on the same edge as DrawX/DrawY.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= w_nx;
            DrawY       <= w_ny;
            hs          <= !(w_nx >= HS_LO && w_nx < HS_HI);
            vs          <= !(w_ny >= VS_LO && w_ny < VS_HI);
            blank       <= w_nx < HV && w_ny < VV;
            line_start  <= w_nx == 10'd0;
            frame_start <= w_nx == 10'd0 && w_ny == 10'd0;
            frame_count <= frame_count + 16'(w_x_end && w_y_end);
        end
    end

    if (PIPE_DELAY == 0) begin : g_nodelay
        assign {hs_d, vs_d, blank_d} = {hs, vs, blank};
    end else begin : g_pipe
        // Each stage holds {hs, vs, blank}; reset fills it with the idle pattern.
        logic [2:0] r_pipe [PIPE_DELAY];
        always_ff @(posedge vga_clk) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DELAY; i++) r_pipe[i] <= 3'b110;
            end else begin
                for (int i = PIPE_DELAY - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
                r_pipe[0] <= {hs, vs, blank};
            end
        end
        assign {hs_d, vs_d, blank_d} = r_pipe[PIPE_DELAY-1];
    end
endmodule
